// File: rtl/thread_rr_arbiter.sv
// ============================================================================
//  thread_rr_arbiter : registered round-robin arbiter, one-hot + binary grant.
//  Optional locked bursts under macro ARBITER_LOCK_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module thread_rr_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      accept,
    input  logic                      lock,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;
    logic [INDEX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
    logic [INDEX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0]    ptr_inc;
    logic                      lock_hold;

    // First set bit of mask at or above ptr, else first set bit below ptr.
    function automatic logic [NUM_REQUESTERS-1:0] rr_pick(
        input logic [NUM_REQUESTERS-1:0] mask,
        input logic [INDEX_WIDTH-1:0]    ptr
    );
        logic [NUM_REQUESTERS-1:0] pick;
        logic                      found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!found && (i >= int'(ptr)) && mask[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!found && (i < int'(ptr)) && mask[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] oh_encode(
        input logic [NUM_REQUESTERS-1:0] oh
    );
        logic [INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = idx | ({INDEX_WIDTH{oh[i]}} & INDEX_WIDTH'(i));
        end
        return idx;
    endfunction

    assign ptr_inc = (grant_idx_q == INDEX_WIDTH'(NUM_REQUESTERS - 1)) ?
                     '0 : grant_idx_q + 1'b1;

`ifdef ARBITER_LOCK_EN
    logic lock_active_q, lock_active_d;

    // A locked accept keeps the owner only while it still requests.
    assign lock_hold = lock & |(request & grant_oh_q);

    always_comb begin
        lock_active_d = lock_active_q;
        if (state_q == GRANTED && accept) begin
            lock_active_d = lock_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_active_q <= 1'b0;
        end else begin
            lock_active_q <= lock_active_d;
        end
    end
`else
    assign lock_hold = lock & 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_oh_d = grant_oh_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (|request) begin
                    grant_oh_d = rr_pick(request, ptr_q);
                    state_d    = GRANTED;
                end
            end
            GRANTED: begin
                if (accept && !lock_hold) begin
                    ptr_d      = ptr_inc;
                    grant_oh_d = rr_pick(request & ~grant_oh_q, ptr_inc);
                    state_d    = (|grant_oh_d) ? GRANTED : IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_oh_d = '0;
            end
        endcase
        grant_idx_d = oh_encode(grant_oh_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant_valid = (state_q == GRANTED);
    assign grant_oh    = grant_oh_q;
    assign grant_idx   = grant_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_thread_rr_arbiter.sv
// ============================================================================
//  tb_thread_rr_arbiter : directed bench for thread_rr_arbiter (N=4 and N=3).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_thread_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic       accept;
    logic       lock;
    logic       grant_valid;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;

    logic [2:0] request3;
    logic       accept3;
    logic       grant_valid3;
    logic [2:0] grant_oh3;
    logic [1:0] grant_idx3;

    int vectors     = 0;
    int miscompares = 0;

    thread_rr_arbiter #(.NUM_REQUESTERS(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .accept      (accept),
        .lock        (lock),
        .grant_valid (grant_valid),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx)
    );

    thread_rr_arbiter #(.NUM_REQUESTERS(3)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .request     (request3),
        .accept      (accept3),
        .lock        (lock),
        .grant_valid (grant_valid3),
        .grant_oh    (grant_oh3),
        .grant_idx   (grant_idx3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        request  = '0;
        accept   = 1'b0;
        lock     = 1'b0;
        request3 = '0;
        accept3  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        request = 4'b1111;
        accept  = 1'b1;
        lock    = 1'b0;
        request3 = '0;
        accept3  = 1'b0;
        tick();
        tick();
        vectors++;
        if (grant_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %0b want 0", grant_valid);
        end
        vectors++;
        if (grant_oh !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_oh: got %b want 0000", grant_oh);
        end
        vectors++;
        if (grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idx: got %0d want 0", grant_idx);
        end
        reset   = 1'b0;
        request = '0;
        accept  = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int         exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_oh;
        do_reset();
        request = 4'b1111;
        accept  = 1'b1;
        vectors++;
        if (grant_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_latency: got valid %0b before edge want 0", grant_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_oh = 4'b0001 << exp_seq[i];
            vectors++;
            if (grant_valid !== 1'b1 || grant_idx !== 2'(exp_seq[i]) || grant_oh !== exp_oh) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got v=%0b idx=%0d oh=%b want v=1 idx=%0d oh=%b",
                         i, grant_valid, grant_idx, grant_oh, exp_seq[i], exp_oh);
            end
        end
        accept = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        request = 4'b1010;
        accept  = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (grant_oh !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold[%0d]: got v=%0b idx=%0d oh=%b want v=1 idx=1 oh=0010",
                         i, grant_valid, grant_idx, grant_oh);
            end
            request = (i % 2 == 0) ? 4'b1111 : 4'b1011;
            tick();
        end
        request = 4'b1010;
        accept  = 1'b1;
        tick();
        accept = 1'b0;
        vectors++;
        if (grant_idx !== 2'd3 || grant_oh !== 4'b1000) begin
            miscompares++;
            $display("FAIL hold_next: got idx=%0d oh=%b want idx=3 oh=1000", grant_idx, grant_oh);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        request = 4'b0100;
        tick();
        vectors++;
        if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got v=%0b idx=%0d want v=1 idx=2", grant_valid, grant_idx);
        end
        reset  = 1'b1;
        accept = 1'b1;
        tick();
        vectors++;
        if (grant_valid !== 1'b0 || grant_oh !== 4'b0000 || grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got v=%0b oh=%b idx=%0d want v=0 oh=0000 idx=0",
                     grant_valid, grant_oh, grant_idx);
        end
        reset  = 1'b0;
        accept = 1'b0;
        tick();
        vectors++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got v=%0b idx=%0d want v=1 idx=2", grant_valid, grant_idx);
        end
    endtask

    task automatic test_accept_idle();
        do_reset();
        request = 4'b0000;
        accept  = 1'b1;
        tick();
        tick();
        vectors++;
        if (grant_valid !== 1'b0 || grant_oh !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_accept: got v=%0b oh=%b want v=0 oh=0000", grant_valid, grant_oh);
        end
        request = 4'b0001;
        tick();
        vectors++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_load: got v=%0b idx=%0d want v=1 idx=0", grant_valid, grant_idx);
        end
        tick();
        accept = 1'b0;
        vectors++;
        if (grant_valid !== 1'b0 || grant_oh !== 4'b0000 || grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL to_idle: got v=%0b oh=%b idx=%0d want v=0 oh=0000 idx=0",
                     grant_valid, grant_oh, grant_idx);
        end
    endtask

    task automatic test_lock();
`ifdef ARBITER_LOCK_EN
        int exp_lock [4] = '{0, 0, 0, 1};
`else
        int exp_lock [4] = '{1, 0, 1, 0};
`endif
        do_reset();
        request = 4'b0011;
        tick();
        vectors++;
        if (grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_first: got v=%0b idx=%0d want v=1 idx=0", grant_valid, grant_idx);
        end
        accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lock = (i < 3);
            tick();
            vectors++;
            if (grant_idx !== 2'(exp_lock[i]) || grant_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL lock_seq[%0d]: got v=%0b idx=%0d want v=1 idx=%0d",
                         i, grant_valid, grant_idx, exp_lock[i]);
            end
        end
        accept = 1'b0;
        lock   = 1'b0;
    endtask

    task automatic test_wrap_n3();
        do_reset();
        request3 = 3'b010;
        tick();
        vectors++;
        if (grant_idx3 !== 2'd1 || grant_oh3 !== 3'b010) begin
            miscompares++;
            $display("FAIL wrap_setup: got idx=%0d oh=%b want idx=1 oh=010", grant_idx3, grant_oh3);
        end
        request3 = 3'b101;
        accept3  = 1'b1;
        tick();
        vectors++;
        if (grant_idx3 !== 2'd2 || grant_oh3 !== 3'b100) begin
            miscompares++;
            $display("FAIL wrap_idx2: got idx=%0d oh=%b want idx=2 oh=100", grant_idx3, grant_oh3);
        end
        tick();
        vectors++;
        if (grant_idx3 !== 2'd0 || grant_oh3 !== 3'b001) begin
            miscompares++;
            $display("FAIL wrap_idx0: got idx=%0d oh=%b want idx=0 oh=001", grant_idx3, grant_oh3);
        end
        request3 = 3'b000;
        tick();
        accept3 = 1'b0;
        vectors++;
        if (grant_valid3 !== 1'b0 || grant_oh3 !== 3'b000) begin
            miscompares++;
            $display("FAIL wrap_idle: got v=%0b oh=%b want v=0 oh=000", grant_valid3, grant_oh3);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_reset_mid_grant();
        test_accept_idle();
        test_lock();
        test_wrap_n3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/thread_rr_arbiter.md
THREAD_RR_ARBITER -- requirements
Module: thread_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of requesters; legal range 2-32.
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(NUM_REQUESTERS), width of the granted index.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port request  input  NUM_REQUESTERS  one bit per requester, bit i = requester i.
REQ-006 SHALL have port accept  input  1  consumer takes the current grant this cycle.
REQ-007 SHALL have port lock  input  1  hold ownership after this accept (functional only with ARBITER_LOCK_EN).
REQ-008 SHALL have port grant_valid  output  1  registered; a grant is presented.
REQ-009 SHALL have port grant_oh  output  NUM_REQUESTERS  registered one-hot grant; all zeros when grant_valid=0.
REQ-010 SHALL have port grant_idx  output  INDEX_WIDTH  binary index of the grant_oh bit, LSB0; 0 when grant_valid=0.

Function
REQ-011 SHALL hold a priority pointer ptr (INDEX_WIDTH bits); requester ptr has highest priority, then ptr+1, ... modulo NUM_REQUESTERS.
REQ-012 SHALL compute the candidate as the first set bit of the arbitration mask, searching from ptr upward with wrap past NUM_REQUESTERS-1 to 0.
REQ-013 SHALL derive grant_idx from grant_oh by OR-reduction encoding, not a priority chain; grant_oh SHALL never have more than one bit set.
REQ-014 SHALL use two states: IDLE (grant_valid=0) and GRANTED (grant_valid=1).
REQ-015 IDLE: if request!=0, load candidate (mask=request, pointer=ptr) into grant_oh and enter GRANTED at the next edge (1-cycle latency); else stay IDLE.
REQ-016 GRANTED, accept=0: grant_oh, grant_idx and ptr SHALL stay unchanged regardless of request changes; requesters hold request until accepted.
REQ-017 GRANTED, accept=1 (lock ignored or 0): ptr <= (grant_idx+1) mod NUM_REQUESTERS; next candidate computed from the updated ptr with mask = request & ~grant_oh.
REQ-018 On accept, if that mask is nonzero the new grant SHALL load at the same edge (back-to-back grants every cycle); else enter IDLE.
REQ-019 Pointer increment SHALL wrap NUM_REQUESTERS-1 -> 0 correctly for non-power-of-two NUM_REQUESTERS.
REQ-020 Any requester continuously requesting SHALL be granted within NUM_REQUESTERS accepts.
REQ-021 accept while grant_valid=0 SHALL be ignored.

Reset
REQ-022 While reset=1 at a rising edge: grant_valid<=0, grant_oh<=0, grant_idx<=0, ptr<=0, state<=IDLE, lock_active<=0.
REQ-023 Reset SHALL take priority over accept and request in the same cycle; an outstanding grant is discarded without ptr update.
REQ-024 First grant after reset deassertion SHALL appear one cycle after request is seen, with requester 0 highest priority.

Configuration
REQ-025 Macro ARBITER_LOCK_EN SHALL control locked bursts.
REQ-026 With ARBITER_LOCK_EN defined: accept=1 with lock=1 SHALL leave ptr unchanged and re-grant the same requester at the next edge if its request bit is still 1, bypassing other requesters; otherwise behave as REQ-017.
REQ-027 With ARBITER_LOCK_EN defined: an accept with lock=0 ends the burst and applies REQ-017.
REQ-028 Without ARBITER_LOCK_EN: lock port SHALL remain present but be ignored; no lock logic synthesized.

Verification
REQ-029 After reset, request=4'b1111, accept=1 every cycle -> grant_idx sequence 0,1,2,3,0 on consecutive cycles, first grant one cycle after request.
REQ-030 request=4'b1010, accept held 0 for 5 cycles -> grant_oh=4'b0010 stable for all 5 cycles, ptr unchanged; accept then -> next grant_idx=3.
REQ-031 NUM_REQUESTERS=3, ptr=2, request=3'b101, accept=1 -> grant_idx 2 then 0 (wrap verified), then IDLE after request drops.
REQ-032 Reset asserted while grant_valid=1, grant_idx=2 -> next cycle grant_valid=0, grant_oh=0, grant_idx=0; with request=4'b0100 after release, grant_idx=2 one cycle later.
REQ-033 ARBITER_LOCK_EN defined, request=4'b0011, grant_idx=0, accept=1 lock=1 for 3 cycles -> grant_idx 0,0,0; lock=0 on fourth accept -> next grant_idx=1.
REQ-034 ARBITER_LOCK_EN undefined, same stimulus as REQ-033 -> grant_idx alternates 0,1,0,1.
